red_pitaya_pwm_dither: RTL and testbench

RED_PITAYA_PWM_DITHER -- requirements
Module: red_pitaya_pwm_dither

---
 rtl/red_pitaya_pwm_dither.sv | 75 +++++++
 tb/tb_red_pitaya_pwm_dither.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_pwm_dither.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | red_pitaya_pwm_dither : 16-period dithered PWM DAC, shadowed per frame   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module red_pitaya_pwm_dither #(
  parameter logic [23:0] INIT_CFG  = 24'h00_0000,
  parameter bit          DITHER_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [23:0] cfg_i,
  output logic        pwm_o,
  output logic        frame_o
);

  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [23:0] shadow_q, shadow_d;
  logic        pwm_q, pwm_d;
  logic        frame_q, frame_d;

  logic [15:0] dither_map;
  logic        dither_bit;
  logic [8:0]  duty;
  logic        period_end;
  logic        frame_end;

  // Nine-bit duty so that B=255 plus a dither bit reaches 256 (always high).
  always_comb begin
    dither_map = shadow_q[15:0];
    dither_bit = DITHER_EN ? dither_map[idx_q] : 1'b0;
    duty       = {1'b0, shadow_q[23:16]} + {8'd0, dither_bit};
    period_end = (cnt_q == 8'hFF);
    frame_end  = period_end && (idx_q == 4'hF);
  end

  always_comb begin
    cnt_d    = 8'd0;
    idx_d    = 4'd0;
    shadow_d = cfg_i;
    pwm_d    = 1'b0;
    frame_d  = 1'b0;
    if (en_i) begin
      cnt_d    = cnt_q + 8'd1;
      idx_d    = period_end ? idx_q + 4'd1 : idx_q;
      // New configuration only lands on the last cycle of a frame.
      shadow_d = frame_end ? cfg_i : shadow_q;
      pwm_d    = ({1'b0, cnt_q} < duty);
      frame_d  = (cnt_q == 8'd0) && (idx_q == 4'd0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= 8'd0;
      idx_q    <= 4'd0;
      shadow_q <= INIT_CFG;
      pwm_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
      frame_q  <= frame_d;
    end
  end

  assign pwm_o   = pwm_q;
  assign frame_o = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_pwm_dither.sv
`default_nettype none
// Scoreboard bench for red_pitaya_pwm_dither: dithered and non-dithered
// instances checked every cycle against a frame-position reference model.
module tb_red_pitaya_pwm_dither;

  localparam logic [23:0] INIT = 24'h30_00A5;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b1;
  logic [23:0] cfg_i = 24'h80_0000;
  logic        pwm1, frm1, pwm0, frm0;

  always #5 clk = ~clk;

  red_pitaya_pwm_dither #(.INIT_CFG(INIT), .DITHER_EN(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .cfg_i(cfg_i),
    .pwm_o(pwm1), .frame_o(frm1)
  );

  red_pitaya_pwm_dither #(.INIT_CFG(INIT), .DITHER_EN(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .cfg_i(cfg_i),
    .pwm_o(pwm0), .frame_o(frm0)
  );

  typedef struct packed {
    logic pwm1;
    logic frm1;
    logic pwm0;
    logic frm0;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_pos = 0;
  logic [23:0] m_cfg = INIT;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: position within the 4096-cycle frame plus the active word.
  task automatic step(input logic r, input logic e, input logic [23:0] c);
    exp_t x;
    int   period, offs, base, dbit;
    @(negedge clk);
    rst_i = r;
    en_i  = e;
    cfg_i = c;
    x = '0;
    if (r) begin
      m_pos = 0;
      m_cfg = INIT;
    end else if (!e) begin
      m_pos = 0;
      m_cfg = c;
    end else begin
      period = m_pos / 256;
      offs   = m_pos % 256;
      base   = int'(m_cfg[23:16]);
      dbit   = int'((m_cfg >> period) & 24'd1);
      x.pwm1 = (offs < base + dbit);
      x.pwm0 = (offs < base);
      x.frm1 = (m_pos == 0);
      x.frm0 = (m_pos == 0);
      if (m_pos == 4095) m_cfg = c;
      m_pos = (m_pos + 1) % 4096;
    end
    sb.push_back(x);
    last_exp = x;
  endtask

  task automatic run(input int n, input logic [23:0] c);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, c);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pwm_dither",   int'(pwm1), int'(e.pwm1));
      check("frame_dither", int'(frm1), int'(e.frm1));
      check("pwm_plain",    int'(pwm0), int'(e.pwm0));
      check("frame_plain",  int'(frm0), int'(e.frm0));
    end
  end

  initial begin
    #100_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] c;
    logic        e;
    int          len;

    #1;
    check("reset_pwm",   int'(pwm1), 0);
    check("reset_frame", int'(frm1), 0);

    // 50% duty from reset: first frame runs INIT, then the applied word.
    repeat (3) step(1'b1, 1'b1, 24'h80_0000);
    run(2 * 4096 + 20, 24'h80_0000);

    // Extremes and dither, each loaded through one disabled cycle.
    step(1'b0, 1'b0, 24'h00_0000);
    run(4096 + 10, 24'h00_0000);
    step(1'b0, 1'b0, 24'hFF_FFFF);
    run(4096 + 10, 24'hFF_FFFF);
    step(1'b0, 1'b0, 24'h10_0001);
    run(4096 + 10, 24'h10_0001);

    // Mid-frame update is deferred to the next frame.
    step(1'b0, 1'b0, 24'h80_0000);
    run(1000, 24'h80_0000);
    run(2 * 4096, 24'h40_0000);

    // Enable dropped during a high phase, then restarted.
    step(1'b0, 1'b0, 24'h80_0000);
    run(50, 24'h80_0000);
    repeat (3) step(1'b0, 1'b0, 24'h80_0000);
    run(300, 24'h80_0000);

    // Asynchronous reset between edges while the output is high.
    step(1'b0, 1'b0, 24'h80_0000);
    run(20, 24'h80_0000);
    @(posedge clk);
    #3;
    check("pwm_before_async_rst", int'(pwm1), int'(last_exp.pwm1));
    rst_i = 1'b1;
    #1;
    check("pwm_async_rst",   int'(pwm1), 0);
    check("pwm0_async_rst",  int'(pwm0), 0);
    repeat (2) step(1'b1, 1'b1, 24'h80_0000);
    run(600, 24'h80_0000);

    // Randomized segments with sporadic cfg changes, disables and resets.
    for (int s = 0; s < 24; s++) begin
      case ($urandom_range(0, 3))
        0:       c = {8'h00, 16'($urandom)};
        1:       c = {8'hFF, 16'($urandom)};
        default: c = 24'($urandom);
      endcase
      e   = 1'b1;
      len = $urandom_range(1, 900);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 49) == 0) c = 24'($urandom);
        if ($urandom_range(0, 149) == 0) e = ~e;
        step($urandom_range(0, 1999) == 0, e, c);
      end
      if ($urandom_range(0, 1) == 1) run(4096, c);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
